fcs_tx_serializer: RTL and testbench
====================================

// Module: fcs_tx_serializer
// PURPOSE
//  Upstream feeder for the 16-bit ITU-T FCS generator (G(x)=x^16+x^12+x^5+1, IEEE 802.15.4-2011 5.2.1.9).
//  Takes PSDU payload bytes over a valid/ready handshake and serializes them LSB-first.
//  Drives crc_data/crc_en into the FCS generator, waits for its result, then appends the 16 FCS bits.
//  The combined payload+FCS bit stream goes out on tx_bit/tx_valid toward the PHY.
// PARAMETERS
//  MAX_PAYLOAD  125  largest legal payload in bytes (aMaxPHYPacketSize 127 minus 2 FCS bytes)
//  FCS_WAIT     2    cycles with crc_en low between the last payload bit and sampling fcs_in
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   one-cycle frame request; honoured only in IDLE
//  frame_len    in   7   payload length in bytes; sampled with start
//  byte_data    in   8   payload byte
//  byte_valid   in   1   byte_data valid
//  byte_ready   out  1   byte accepted when byte_valid & byte_ready
//  crc_data     out  1   serial bit to the FCS generator
//  crc_en       out  1   crc_data valid for the FCS generator
//  fcs_in       in   16  FCS result from the generator
//  tx_bit       out  1   serial output: payload bits, then FCS bits
//  tx_valid     out  1   tx_bit valid
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse after the last FCS bit
//  len_err      out  1   one-cycle pulse when start carries an illegal frame_len
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0.
//  Data path: tx_bit == crc_data during payload; tx_valid == crc_en during payload.
//  States: IDLE, LOAD, SHIFT, WAIT, FCS, DONE.
//  IDLE: start with 1 <= frame_len <= MAX_PAYLOAD latches the length; go to LOAD next cycle.
//    Illegal frame_len (0 or > MAX_PAYLOAD): len_err pulses next cycle; stay in IDLE.
//  LOAD: byte_ready = 1. On handshake, latch the byte, bit_idx = 0, go to SHIFT.
//  SHIFT: each cycle drive byte[bit_idx] (LSB first) with crc_en = tx_valid = 1.
//    At bit_idx 7, byte_ready = 1 (prefetch).
//    At bit_idx 7 with a handshake and bytes remaining: load the new byte; next cycle is its bit 0 (no gap).
//    At bit_idx 7, no handshake, bytes remaining: go to LOAD. That costs a 1+ cycle bubble with crc_en = tx_valid = 0.
//    At bit_idx 7 on the last byte: byte_ready = 0; go to WAIT.
//  WAIT: crc_en = tx_valid = 0 for FCS_WAIT cycles. Then latch fcs_in and go to FCS.
//  FCS: 16 cycles, tx_valid = 1, tx_bit = fcs[15] first down to fcs[0]. crc_en = 0.
//  DONE: done = 1 for one cycle; busy = 0 from the next cycle (IDLE).
//  Counters: byte counter is 7 bits, counts down from frame_len; bit counter is 4 bits (reused for FCS); no wrap.
//  Latency: start at cycle 0 with byte_valid held high gives:
//    handshake in cycle 1;
//    first tx bit in cycle 2;
//    payload bits contiguous for 8*N cycles;
//    FCS bits start at 2+8N+FCS_WAIT;
//    done at cycle 18+8N+FCS_WAIT.
//  start while busy: ignored, no len_err.
//  byte_ready is never high outside LOAD/SHIFT.
//  rst_n low mid-frame: immediate return to IDLE, outputs 0, partial frame dropped.
//    The downstream generator shares rst_n and clears with it.
// CONFIGURATION
//  FCS_TX_STATS_EN defined:
//    adds output frame_cnt[15:0], reset 0, +1 on each done pulse, wraps 0xFFFF->0;
//    adds output err_cnt[7:0], +1 per len_err, saturates at 0xFF.
//  Not defined: neither port exists and no counter logic is built.
// TESTING
//  1. frame_len=1, byte 0xB1, valid held, fcs_in=0xA5C3 -> payload bits 1,0,0,0,1,1,0,1.
//     Then 2 idle cycles, then FCS bits 1010010111000011, then done at cycle 28.
//  2. frame_len=3, bytes 0x01,0x80,0xFF, back-to-back -> 24 contiguous tx_valid cycles.
//     byte_ready high at bit_idx 7 of bytes 1 and 2 only.
//  3. frame_len=2, second byte_valid delayed 5 cycles -> tx_valid/crc_en low for 5+ cycles.
//     Then stream resumes; total payload tx_valid count is 16.
//  4. start with frame_len=0, then start with frame_len=126 -> len_err pulses twice.
//     busy stays 0 and there is no tx activity.
//  5. start pulsed mid-frame -> ignored. rst_n low at payload bit 10 -> all outputs 0 immediately.
//     A new frame after rst_n release completes normally.
//  6. FCS_TX_STATS_EN, 3 good frames + 1 bad length -> frame_cnt=3, err_cnt=1.

Source files
------------

// File: rtl/fcs_tx_serializer.sv
// PSDU byte-to-bit serializer feeding a serial 16-bit FCS generator, then appending its FCS MSB-first.
// Optional FCS_TX_STATS_EN adds frame_cnt/err_cnt statistics outputs. FCS_WAIT must be in 1..16.
module fcs_tx_serializer #(
  parameter int MAX_PAYLOAD = 125,
  parameter int FCS_WAIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  frame_len,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        crc_data,
  output logic        crc_en,
  input  logic [15:0] fcs_in,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic        len_err
`ifdef FCS_TX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAIT, FCS, DONE} state_t;

  localparam logic [7:0] MAX_LEN   = 8'(MAX_PAYLOAD);
  localparam logic [3:0] WAIT_LAST = 4'(FCS_WAIT - 1);

  state_t      state;
  logic [6:0]  byte_cnt;   // bytes still to be fetched
  logic [3:0]  bit_idx;    // payload bit, WAIT cycle or FCS bit index
  logic [7:0]  shreg;
  logic [15:0] fcs_sh;

  logic       take;
  logic       len_ok;
  logic [2:0] nxt_bit;

  assign take    = byte_valid & byte_ready;
  assign len_ok  = (frame_len != 7'd0) && ({1'b0, frame_len} <= MAX_LEN);
  assign nxt_bit = bit_idx[2:0] + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      fcs_sh     <= '0;
      byte_ready <= 1'b0;
      crc_data   <= 1'b0;
      crc_en     <= 1'b0;
      tx_bit     <= 1'b0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      len_err    <= 1'b0;
`ifdef FCS_TX_STATS_EN
      frame_cnt  <= '0;
      err_cnt    <= '0;
`endif
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      if (take) begin
        // Byte accepted in LOAD or as a prefetch at bit 7: its bit 0 goes out next cycle.
        shreg      <= byte_data;
        byte_cnt   <= byte_cnt - 7'd1;
        bit_idx    <= '0;
        state      <= SHIFT;
        byte_ready <= 1'b0;
        crc_en     <= 1'b1;
        tx_valid   <= 1'b1;
        crc_data   <= byte_data[0];
        tx_bit     <= byte_data[0];
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (len_ok) begin
                byte_cnt   <= frame_len;
                state      <= LOAD;
                byte_ready <= 1'b1;
                busy       <= 1'b1;
              end else begin
                len_err <= 1'b1;
`ifdef FCS_TX_STATS_EN
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
              end
            end
          end
          LOAD: ;
          SHIFT: begin
            if (bit_idx[2:0] != 3'd7) begin
              bit_idx    <= bit_idx + 4'd1;
              crc_data   <= shreg[nxt_bit];
              tx_bit     <= shreg[nxt_bit];
              byte_ready <= (bit_idx[2:0] == 3'd6) && (byte_cnt != 7'd0);
            end else begin
              crc_en   <= 1'b0;
              tx_valid <= 1'b0;
              crc_data <= 1'b0;
              tx_bit   <= 1'b0;
              if (byte_cnt == 7'd0) begin
                state      <= WAIT;
                bit_idx    <= '0;
                byte_ready <= 1'b0;
              end else begin
                // Next byte not offered yet: hold ready and stall in LOAD.
                state      <= LOAD;
                byte_ready <= 1'b1;
              end
            end
          end
          WAIT: begin
            if (bit_idx == WAIT_LAST) begin
              fcs_sh   <= {fcs_in[14:0], 1'b0};
              tx_bit   <= fcs_in[15];
              tx_valid <= 1'b1;
              bit_idx  <= '0;
              state    <= FCS;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          FCS: begin
            if (bit_idx == 4'd15) begin
              state    <= DONE;
              tx_valid <= 1'b0;
              tx_bit   <= 1'b0;
              done     <= 1'b1;
`ifdef FCS_TX_STATS_EN
              frame_cnt <= frame_cnt + 16'd1;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx_bit  <= fcs_sh[15];
              fcs_sh  <= {fcs_sh[14:0], 1'b0};
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fcs_tx_serializer.sv
// Bench for fcs_tx_serializer: a frame-level model expands each accepted start into the expected bit stream.
// One negedge process compares every output cycle against it; directed frames add literal timing pins.
module tb_fcs_tx_serializer;
  localparam int FCS_WAIT = 2;
  localparam int MAXP     = 125;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  frame_len = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic [15:0] fcs_in = '0;
  logic        byte_ready, crc_data, crc_en, tx_bit, tx_valid, busy, done, len_err;
`ifdef FCS_TX_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  fcs_tx_serializer #(.MAX_PAYLOAD(MAXP), .FCS_WAIT(FCS_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .crc_data(crc_data), .crc_en(crc_en), .fcs_in(fcs_in),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done), .len_err(len_err)
`ifdef FCS_TX_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] pl [0:127];

  // per-frame expectations set by the stimulus
  int exp_done_rel = -1;
  int exp_br       = -1;
  int exp_min_gap  = 0;
  bit exp_contig   = 1'b0;
  bit exp_lit      = 1'b0;
  bit stats_req    = 1'b0;

  // model and scoreboard state, owned by the compare process
  int checks = 0, errors = 0;
  bit exp_bits[$];
  bit exp_pay[$];
  bit active = 1'b0, act_pend = 1'b0, done_prev = 1'b0;
  int f_start = 0, f_len = 0, lerr_cyc = -1, rel = 0;
  int pay_cnt = 0, first_pay = 0, last_pay = 0, max_gap = 0, br_cnt = 0;
  logic [23:0] cap = '0, mb = '0;
  bit eb, ep;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk({byte_ready, crc_data, crc_en, tx_bit, tx_valid, busy, done, len_err} == 8'd0,
          "reset_outputs", {byte_ready, crc_data, crc_en, tx_bit, tx_valid, busy, done, len_err}, 0);
      exp_bits.delete(); exp_pay.delete();
      active = 1'b0; act_pend = 1'b0; done_prev = 1'b0; lerr_cyc = -1;
    end else begin
      rel = cyc - f_start;
      if (act_pend) begin active = 1'b1; act_pend = 1'b0; end
      if (done_prev) begin active = 1'b0; done_prev = 1'b0; end
      chk(busy == active, "busy", busy, active);
      chk(len_err == (cyc == lerr_cyc), "len_err", len_err, cyc == lerr_cyc);
      if (byte_ready) chk(busy, "byte_ready_idle", busy, 1);
      if (tx_valid) begin
        if (exp_bits.size() == 0) chk(1'b0, "tx_unexpected", tx_valid, 0);
        else begin
          eb = exp_bits.pop_front();
          ep = exp_pay.pop_front();
          chk(tx_bit == eb, "tx_bit", tx_bit, eb);
          chk(crc_en == ep, "crc_en", crc_en, ep);
          if (ep) chk(crc_data == tx_bit, "crc_data", crc_data, tx_bit);
          cap = {cap[22:0], tx_bit};
          if (ep) begin
            if (pay_cnt == 0) first_pay = rel;
            else if (rel - last_pay - 1 > max_gap) max_gap = rel - last_pay - 1;
            last_pay = rel;
            pay_cnt++;
            if (byte_ready) br_cnt++;
          end else if (exp_bits.size() == 15) begin
            chk(rel - last_pay == FCS_WAIT + 1, "fcs_gap", rel - last_pay, FCS_WAIT + 1);
          end
        end
      end else begin
        chk(crc_en == 1'b0, "crc_en_idle", crc_en, 0);
      end
      if (done) begin
        chk(active, "done_spurious", done, active);
        chk(exp_bits.size() == 0, "done_early", exp_bits.size(), 0);
        chk(pay_cnt == 8 * f_len, "payload_count", pay_cnt, 8 * f_len);
        if (exp_done_rel >= 0) chk(rel == exp_done_rel, "done_cycle", rel, exp_done_rel);
        if (exp_contig) chk(last_pay - first_pay + 1 == 8 * f_len, "contiguous", last_pay - first_pay + 1, 8 * f_len);
        if (exp_br >= 0) chk(br_cnt == exp_br, "prefetch_ready", br_cnt, exp_br);
        if (exp_min_gap > 0) chk(max_gap >= exp_min_gap, "bubble", max_gap, exp_min_gap);
        if (exp_lit) chk(cap == 24'b10001101_1010010111000011, "stream_literal", cap, 24'b10001101_1010010111000011);
        done_prev = 1'b1;
      end
      if (start && !active && !act_pend) begin
        if (frame_len >= 1 && frame_len <= MAXP) begin
          exp_bits.delete(); exp_pay.delete();
          for (int i = 0; i < int'(frame_len); i++)
            for (int k = 0; k < 8; k++) begin exp_bits.push_back(pl[i][k]); exp_pay.push_back(1'b1); end
          for (int k = 15; k >= 0; k--) begin exp_bits.push_back(fcs_in[k]); exp_pay.push_back(1'b0); end
          if (exp_lit) begin
            for (int i = 0; i < 24; i++) mb = {mb[22:0], exp_bits[i]};
            chk(mb == 24'b10001101_1010010111000011, "model_literal", mb, 24'b10001101_1010010111000011);
          end
          f_start = cyc; f_len = int'(frame_len); act_pend = 1'b1;
          pay_cnt = 0; first_pay = 0; last_pay = 0; max_gap = 0; br_cnt = 0; cap = '0;
        end else begin
          lerr_cyc = cyc + 1;
        end
      end
`ifdef FCS_TX_STATS_EN
      if (stats_req) begin
        chk(frame_cnt == 16'd3, "frame_cnt", frame_cnt, 3);
        chk(err_cnt == 8'd1, "err_cnt", err_cnt, 1);
      end
`endif
    end
  end

  task automatic run_frame(input int len, input logic [15:0] fcs, input int stall_after,
                           input int stall_cycles, input int mid_at, input int rst_at);
    int idx, sc, s0, r;
    bit hs, dn;
    fcs_in = fcs;
    @(posedge clk); #1;
    start = 1'b1; frame_len = 7'(len); byte_valid = 1'b1; byte_data = pl[0];
    idx = 0; sc = 0; s0 = cyc; dn = 1'b0;
    for (int n = 0; n < 1200 && !dn; n++) begin
      @(negedge clk);
      hs = byte_valid && byte_ready;
      dn = done;
      @(posedge clk); #1;
      start = 1'b0;
      r = cyc - s0;
      if (sc > 0) begin
        sc--;
        if (sc == 0) begin byte_valid = 1'b1; byte_data = pl[idx]; end
      end else if (hs) begin
        idx++;
        if (idx >= len) byte_valid = 1'b0;
        else if (idx == stall_after + 1 && stall_cycles > 0) begin byte_valid = 1'b0; sc = stall_cycles; end
        else byte_data = pl[idx];
      end
      if (mid_at >= 0 && r == mid_at) begin start = 1'b1; frame_len = 7'd1; end
      if (mid_at >= 0 && r == mid_at + 2) begin start = 1'b1; frame_len = 7'd0; end
      if (r == rst_at) begin
        rst_n = 1'b0; byte_valid = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
    end
    if (!dn) begin
      $display("FAIL frame_timeout: no done within budget for len %0d", len);
      $fatal(1);
    end
    byte_valid = 1'b0;
  endtask

  task automatic set_exp(input int d, input int br, input int gap, input bit contig, input bit lit);
    exp_done_rel = d; exp_br = br; exp_min_gap = gap; exp_contig = contig; exp_lit = lit;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single byte, literal stream and done at cycle 28
    pl[0] = 8'hB1;
    set_exp(28, 0, 0, 1'b1, 1'b1);
    run_frame(1, 16'hA5C3, -1, 0, -1, -1);

    // three bytes back-to-back with prefetch
    pl[0] = 8'h01; pl[1] = 8'h80; pl[2] = 8'hFF;
    set_exp(18 + 24 + FCS_WAIT, 2, 0, 1'b1, 1'b0);
    run_frame(3, 16'h1234, -1, 0, -1, -1);

    // second byte late: bubble in the payload stream
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    set_exp(-1, 1, 5, 1'b0, 1'b0);
    run_frame(2, 16'hBEEF, 0, 13, -1, -1);

    // illegal lengths 0 and 126
    @(posedge clk); #1 start = 1'b1; frame_len = 7'd0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; frame_len = 7'd126;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);

    // largest legal payload
    for (int i = 0; i < MAXP; i++) pl[i] = 8'(i * 37 + 5);
    set_exp(18 + 8 * MAXP + FCS_WAIT, MAXP - 1, 0, 1'b1, 1'b0);
    run_frame(MAXP, 16'h0F0F, -1, 0, -1, -1);

    // starts while busy, then reset at payload bit 10
    pl[0] = 8'h3C; pl[1] = 8'h96; pl[2] = 8'h0F;
    set_exp(-1, -1, 0, 1'b0, 1'b0);
    run_frame(3, 16'h5555, -1, 0, 6, 12);
    repeat (2) @(posedge clk);
    pl[0] = 8'hE7; pl[1] = 8'h18;
    set_exp(18 + 16 + FCS_WAIT, 1, 0, 1'b1, 1'b0);
    run_frame(2, 16'h8001, -1, 0, -1, -1);

    // two more good frames and one bad length for the statistics
    pl[0] = 8'h00;
    set_exp(18 + 8 + FCS_WAIT, 0, 0, 1'b1, 1'b0);
    run_frame(1, 16'hFFFF, -1, 0, -1, -1);
    pl[0] = 8'hA5; pl[1] = 8'h5A; pl[2] = 8'h12; pl[3] = 8'h34;
    set_exp(18 + 32 + FCS_WAIT, 3, 0, 1'b1, 1'b0);
    run_frame(4, 16'h0000, -1, 0, -1, -1);
    @(posedge clk); #1 start = 1'b1; frame_len = 7'd127;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 stats_req = 1'b1;
    @(posedge clk); #1 stats_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
